data_sram_resp: RTL and testbench
=================================

# data_sram_resp

Responder for the CPU core's data SRAM port. It accepts the core's `data_sram_en/we/addr/wdata` requests and returns `data_sram_rdata` with fixed one-cycle latency. Requests go either to a local word-addressed RAM or to a small memory-mapped register window: LED register, switch input, free-running timer, and a 4-entry byte TX FIFO drained over a valid/ready handshake. It sits beside the core at SoC level and terminates the core's data-side interface.

## Interface
Parameters:
- RAM_AW, 12, RAM word-address width (2^RAM_AW 32-bit words)
- MMIO_BASE, 16'hBFAF, value of `addr[31:16]` that selects the register window

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- data_sram_en  input  1  request valid this cycle
- data_sram_we  input  4  byte write enables; 0 means read
- data_sram_addr  input  32  byte address; `[1:0]` ignored
- data_sram_wdata  input  32  write data
- data_sram_rdata  output  32  read data, registered
- switch  input  16  board switches, read-only via MMIO
- led  output  16  LED register
- tx_valid  output  1  FIFO head valid
- tx_data  output  8  FIFO head byte
- tx_ready  input  1  consumer accepts head

## Operation
- Decode on `data_sram_en`:
  - MMIO when `addr[31:16]==MMIO_BASE`.
  - Otherwise RAM at index `addr[RAM_AW+1:2]`; higher bits alias.
- RAM:
  - Write: each byte lane i is written when `we[i]`.
  - Read (`we==0`): the word is returned next cycle.
  - RAM contents are not reset.
- MMIO offsets (`addr[15:0]`):
  - 0x8000 LED:
    - Read gives `{16'b0, led}`.
    - `we[0]` writes `led[7:0]`; `we[1]` writes `led[15:8]`.
  - 0x8004 SWITCH:
    - Read gives `{16'b0, switch}`, sampled in the request cycle.
    - Writes are ignored.
  - 0x8008 TIMER:
    - 32-bit counter, +1 every cycle, wraps at 0xFFFFFFFF to 0.
    - A byte-enabled write replaces the selected bytes; a write wins over the increment that cycle.
    - A read returns the pre-increment value of the request cycle.
  - 0x8010 TX_PUSH:
    - Write with `we[0]` pushes `wdata[7:0]`.
    - Reads return 0.
  - 0x8014 TX_STAT:
    - Read gives `{26'b0, count[2:0], overflow, full, empty}`.
    - Write with `we[0]` and `wdata[2]=1` clears `overflow`.
  - Any other offset reads 0; writes to it are ignored.
- TX FIFO: 4 entries, circular, 2-bit read/write pointers plus a 3-bit count.
  - `tx_valid = (count!=0)`.
  - `tx_data` = head byte when valid, else 8'h00.
  - Pop when `tx_valid && tx_ready`.
  - A push is accepted when `count<4`, or when `count==4` and a pop happens the same cycle.
  - A rejected push is dropped and sets sticky `overflow`.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - A push into an empty FIFO is visible on `tx_valid` the next cycle; there is no bypass.

## Timing
- Read latency is exactly 1 cycle: request in cycle N, `data_sram_rdata` valid in cycle N+1.
- `data_sram_rdata` holds its previous value in cycles with `en=0` or `we!=0`.
- Back-to-back requests are accepted every cycle with no stall. The block has no backpressure toward the core.
- A read of a RAM word written in cycle N, issued in cycle N+1, returns the new data.
- MMIO register writes take effect at the clock edge ending the request cycle.
- Reset (asynchronous, also mid-operation) forces:
  - `data_sram_rdata=0`, `led=0`, timer=0;
  - FIFO pointers and count =0, `overflow=0`;
  - hence `tx_valid=0` and `tx_data=0`.
  - RAM is untouched.

## Configuration
- `DATA_SRAM_RESP_TIMER_EN` defined:
  - TIMER register present as described.
- Not defined:
  - No counter flops.
  - Offset 0x8008 reads 0 and writes are ignored, like an unmapped offset.

## Test plan
- RAM byte lanes:
  - Write 0x11223344 to 0x1C000100 with `we=4'hF`.
  - Then write 0xAA000000 to the same address with `we=4'h8`.
  - Read the same address → `rdata=0xAA223344` one cycle after the read.
- Aliasing and latency:
  - Write 0xDEADBEEF to RAM word 0.
  - Read address `(1<<(RAM_AW+2))` → 0xDEADBEEF, exactly 1 cycle after the request.
  - `rdata` holds during the following idle cycles.
- LED and switch:
  - Write 0x0000A5C3 to 0xBFAF8000 with `we=4'h1` → `led=0x00C3`.
  - Drive `switch=0x1234`, read 0xBFAF8004 → 0x00001234.
- TX FIFO with `tx_ready=0`:
  - Push 0x41, 0x42, 0x43, 0x44, 0x45 → `count=4`, `full=1`, `overflow=1`, `tx_data=0x41`.
  - Set `tx_ready=1` → 0x41..0x44 appear on consecutive cycles; then `tx_valid=0`.
  - Write 0x4 to TX_STAT with `we[0]` → reads 0x00000001.
- Timer (macro on):
  - Write 0xFFFFFFFE to 0xBFAF8008.
  - Read in the following two cycles → 0xFFFFFFFE, then 0xFFFFFFFF; the read after that → 0x00000000.
- Mid-operation reset:
  - With FIFO `count=3` and `led=0xFFFF`, assert reset for one cycle.
  - → `tx_valid=0`, `led=0`, `rdata=0` immediately.
  - RAM word written before reset still reads back unchanged.

Source files
------------

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: word RAM plus an MMIO window (LED, switches, TX FIFO, timer).
// Define DATA_SRAM_RESP_TIMER_EN to build the free-running timer at offset 0x8008.
module data_sram_resp #(
  parameter int          RAM_AW    = 12,
  parameter logic [15:0] MMIO_BASE = 16'hBFAF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam logic [15:0] OFF_LED   = 16'h8000;
  localparam logic [15:0] OFF_SW    = 16'h8004;
  localparam logic [15:0] OFF_TIMER = 16'h8008;
  localparam logic [15:0] OFF_PUSH  = 16'h8010;
  localparam logic [15:0] OFF_STAT  = 16'h8014;

  logic [31:0] mem [2**RAM_AW];

  logic              is_mmio, is_ram, wr, rd;
  logic [15:0]       off;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       rd_word;

  assign is_mmio = data_sram_en && (data_sram_addr[31:16] == MMIO_BASE);
  assign is_ram  = data_sram_en && !is_mmio;
  assign off     = data_sram_addr[15:0];
  assign wr      = |data_sram_we;
  assign rd      = data_sram_en && !wr;
  assign ram_idx = data_sram_addr[RAM_AW+1:2];

  // RAM has no reset so it keeps its contents across a core reset.
  always_ff @(posedge clk) begin
    if (is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  logic       led_wr;
  assign led_wr = is_mmio && (off == OFF_LED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led <= '0;
    end else if (led_wr) begin
      if (data_sram_we[0]) led[7:0]  <= data_sram_wdata[7:0];
      if (data_sram_we[1]) led[15:8] <= data_sram_wdata[15:8];
    end
  end

`ifdef DATA_SRAM_RESP_TIMER_EN
  logic [31:0] timer;
  logic        timer_wr;
  assign timer_wr = is_mmio && (off == OFF_TIMER) && wr;

  // A software write freezes unselected bytes for that cycle instead of incrementing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (timer_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) timer[8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end else begin
      timer <= timer + 32'd1;
    end
  end
`endif

  logic [7:0] fifo_mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;
  logic       overflow, full, empty;
  logic       push_req, push_ok, pop, stat_clr;

  assign full     = (count == 3'd4);
  assign empty    = (count == 3'd0);
  assign tx_valid = !empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign pop      = tx_valid && tx_ready;
  assign push_req = is_mmio && (off == OFF_PUSH) && data_sram_we[0];
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign stat_clr = is_mmio && (off == OFF_STAT) && data_sram_we[0] && data_sram_wdata[2];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= data_sram_wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      if (push_ok && !pop)      count <= count + 3'd1;
      else if (pop && !push_ok) count <= count - 3'd1;
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (stat_clr)        overflow <= 1'b0;
    end
  end

  always_comb begin
    rd_word = '0;
    if (!is_mmio) begin
      rd_word = mem[ram_idx];
    end else begin
      case (off)
        OFF_LED:   rd_word = {16'b0, led};
        OFF_SW:    rd_word = {16'b0, switch};
`ifdef DATA_SRAM_RESP_TIMER_EN
        OFF_TIMER: rd_word = timer;
`endif
        OFF_STAT:  rd_word = {26'b0, count, overflow, full, empty};
        default:   rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   data_sram_rdata <= '0;
    else if (rd) data_sram_rdata <= rd_word;
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: driver updates a queue/array model, monitor checks outputs.
// Timer checks are included when DATA_SRAM_RESP_TIMER_EN is defined.
module tb_data_sram_resp;

  localparam int RAM_AW = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] switch;
  logic [15:0] led;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  data_sram_resp #(.RAM_AW(RAM_AW), .MMIO_BASE(16'hBFAF)) dut (
    .clk(clk), .reset(reset),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .switch(switch), .led(led),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] ram_m [int];
  logic [15:0] led_m;
  logic [7:0]  fifo_m[$];
  logic        overflow_m;
`ifdef DATA_SRAM_RESP_TIMER_EN
  logic [31:0] timer_m;
`endif

  // Scoreboard queues
  logic [31:0] exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [31:0] hold;
  logic        rd_pend, pop_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic reset_model();
    led_m = '0;
    fifo_m.delete();
    tx_exp_q.delete();
    exp_q.delete();
    overflow_m = 1'b0;
    hold = '0;
`ifdef DATA_SRAM_RESP_TIMER_EN
    timer_m = '0;
`endif
  endtask

  // Drives one request and advances the model to the state after the next rising edge.
  // Called at negedge+1; returns at the following negedge+1.
  task automatic issue(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic has_c, input logic [31:0] c);
    logic [31:0] r, cur;
    logic        mm, pop, push, ok;
    logic [15:0] o;
    int          idx, sz;
    data_sram_en = e; data_sram_we = w; data_sram_addr = a; data_sram_wdata = d;
    mm  = (a[31:16] == 16'hBFAF);
    o   = a[15:0];
    idx = int'((a >> 2) & ((32'd1 << RAM_AW) - 1));
    sz  = fifo_m.size();
    r   = '0;
    if (!mm) r = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
    else begin
      case (o)
        16'h8000: r = {16'b0, led_m};
        16'h8004: r = {16'b0, switch};
`ifdef DATA_SRAM_RESP_TIMER_EN
        16'h8008: r = timer_m;
`endif
        16'h8014: r = {26'b0, 3'(sz), overflow_m, sz == 4, sz == 0};
        default:  r = '0;
      endcase
    end
    if (e && w == 4'h0) exp_q.push_back(has_c ? c : r);
    if (e && !mm && w != 4'h0) begin
      cur = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (w[i]) cur[8*i +: 8] = d[8*i +: 8];
      ram_m[idx] = cur;
    end
    if (e && mm && o == 16'h8000) begin
      if (w[0]) led_m[7:0]  = d[7:0];
      if (w[1]) led_m[15:8] = d[15:8];
    end
    pop  = (sz > 0) && tx_ready;
    push = e && mm && o == 16'h8010 && w[0];
    ok   = push && (sz < 4 || pop);
    if (pop) void'(fifo_m.pop_front());
    if (ok) begin
      fifo_m.push_back(d[7:0]);
      tx_exp_q.push_back(d[7:0]);
    end
    if (push && !ok) overflow_m = 1'b1;
    else if (e && mm && o == 16'h8014 && w[0] && d[2]) overflow_m = 1'b0;
`ifdef DATA_SRAM_RESP_TIMER_EN
    if (e && mm && o == 16'h8008 && w != 4'h0) begin
      for (int i = 0; i < 4; i++) if (w[i]) timer_m[8*i +: 8] = d[8*i +: 8];
    end else begin
      timer_m = timer_m + 32'd1;
    end
`endif
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic rd_const(input logic [31:0] a, input logic [31:0] c);
    issue(1'b1, 4'h0, a, $urandom, 1'b1, c);
  endtask

  task automatic wr(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    issue(1'b1, w, a, d, 1'b0, 32'h0);
  endtask

  // Handshake capture: which cycles carried a read and which carried a TX pop.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      pop_pend <= 1'b0;
    end else begin
      rd_pend  <= data_sram_en && (data_sram_we == 4'h0);
      pop_pend <= tx_valid && tx_ready;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_pend) begin
        if (exp_q.size() == 0) chk("rdata_unexpected", data_sram_rdata, 32'hxxxxxxxx);
        else begin
          hold = exp_q.pop_front();
          chk("rdata", data_sram_rdata, hold);
        end
      end else begin
        chk("rdata_hold", data_sram_rdata, hold);
      end
      chk("led", {16'b0, led}, {16'b0, led_m});
      if (pop_pend && tx_exp_q.size() > 0) void'(tx_exp_q.pop_front());
      chk("tx_valid", {31'b0, tx_valid}, {31'b0, tx_exp_q.size() != 0});
      if (tx_exp_q.size() != 0) chk("tx_data", {24'b0, tx_data}, {24'b0, tx_exp_q[0]});
      else chk("tx_data_idle", {24'b0, tx_data}, 32'h0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    reset = 1'b1;
    data_sram_en = 1'b0; data_sram_we = '0; data_sram_addr = '0; data_sram_wdata = '0;
    switch = '0; tx_ready = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rdata", data_sram_rdata, 32'h0);
    chk("reset_led", {16'b0, led}, 32'h0);
    chk("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("reset_tx_data", {24'b0, tx_data}, 32'h0);
    reset = 1'b0;

    // Byte lanes
    wr(4'hF, 32'h1C00_0100, 32'h1122_3344);
    wr(4'h8, 32'h1C00_0100, 32'hAA00_0000);
    rd_const(32'h1C00_0100, 32'hAA22_3344);
    // Aliasing, latency, hold
    wr(4'hF, 32'h0000_0000, 32'hDEAD_BEEF);
    rd_const(32'h1 << (RAM_AW + 2), 32'hDEAD_BEEF);
    idle(3);
    // LED and switches
    wr(4'h1, 32'hBFAF_8000, 32'h0000_A5C3);
    rd_const(32'hBFAF_8000, 32'h0000_00C3);
    switch = 16'h1234;
    rd_const(32'hBFAF_8004, 32'h0000_1234);
    rd_const(32'hBFAF_800C, 32'h0);
    // FIFO fill and overflow
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(4'h1, 32'hBFAF_8010, 32'h41 + i);
    rd_const(32'hBFAF_8014, 32'h0000_0026);
    rd_const(32'hBFAF_8010, 32'h0);
    tx_ready = 1'b1;
    idle(6);
    tx_ready = 1'b0;
    wr(4'h1, 32'hBFAF_8014, 32'h4);
    rd_const(32'hBFAF_8014, 32'h0000_0001);
`ifdef DATA_SRAM_RESP_TIMER_EN
    wr(4'hF, 32'hBFAF_8008, 32'hFFFF_FFFE);
    rd_const(32'hBFAF_8008, 32'hFFFF_FFFE);
    rd_const(32'hBFAF_8008, 32'hFFFF_FFFF);
    rd_const(32'hBFAF_8008, 32'h0000_0000);
`else
    wr(4'hF, 32'hBFAF_8008, 32'hFFFF_FFFE);
    rd_const(32'hBFAF_8008, 32'h0);
`endif

    // Mid-operation reset
    for (int i = 0; i < 3; i++) wr(4'h1, 32'hBFAF_8010, 32'h60 + i);
    wr(4'h3, 32'hBFAF_8000, 32'h0000_FFFF);
    wr(4'hF, 32'h0000_0200, 32'h5A5A_A5A5);
    rd_const(32'h0000_0100, 32'hAA22_3344);
    data_sram_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("midrst_tx_data", {24'b0, tx_data}, 32'h0);
    chk("midrst_led", {16'b0, led}, 32'h0);
    chk("midrst_rdata", data_sram_rdata, 32'h0);
    reset_model();
    #1 reset = 1'b0;
    idle(1);
    rd_const(32'h0000_0200, 32'h5A5A_A5A5);

    // Random traffic over 16 pre-filled words
    for (int i = 0; i < 16; i++) wr(4'hF, i * 4, $urandom);
    for (int n = 0; n < 400; n++) begin
      tx_ready = 1'($urandom_range(0, 1));
      switch   = 16'($urandom);
      a = (32'($urandom_range(0, 7)) << 14) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
      w = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 9))
        0:       issue(1'b1, w, a, $urandom, 1'b0, 32'h0);
        1, 2:    issue(1'b1, 4'h0, a, $urandom, 1'b0, 32'h0);
        3:       issue(1'b1, w, 32'hBFAF_8000, $urandom, 1'b0, 32'h0);
        4:       issue(1'b1, 4'h0, 32'hBFAF_8000 | (32'($urandom_range(0, 3)) << 2), 0, 1'b0, 32'h0);
        5, 6:    issue(1'b1, w, 32'hBFAF_8010, $urandom, 1'b0, 32'h0);
        7:       issue(1'b1, 4'($urandom_range(0, 1)), 32'hBFAF_8014, $urandom, 1'b0, 32'h0);
        8:       issue(1'b1, 4'($urandom_range(0, 1)) * w, 32'hBFAF_8008, $urandom, 1'b0, 32'h0);
        default: idle(1);
      endcase
    end
    tx_ready = 1'b1;
    idle(8);
    chk("exp_q_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
